rx_bit_sampler: RTL and testbench
=================================

RX_BIT_SAMPLER -- requirements
Module: rx_bit_sampler

Interface
REQ-001 Parameter OVERSAMPLE, default 16: baud_tick pulses per serial bit period (even, 8..32).
REQ-002 Parameter DATA_BITS, default 8: data bits per frame, LSB first.
REQ-003 clock  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 baud_tick  input  1  one-clock enable strobe at OVERSAMPLE x baud rate.
REQ-006 rx_enable  input  1  high = sampler armed; low = hold/abort to IDLE.
REQ-007 rx_in  input  1  asynchronous serial line, idle high.
REQ-008 rx_bit  output  1  last sampled bit value, held until next sample.
REQ-009 rx_data_signal  output  1  one-clock strobe: rx_bit valid (data, parity or stop bit).
REQ-010 start_check  output  1  one-clock strobe: valid start bit confirmed at mid-bit.
REQ-011 bit_index  output  4  index of bit just strobed: 0..DATA_BITS-1 data, DATA_BITS parity, DATA_BITS+1 stop.
REQ-012 stop_check  output  1  registered with stop-bit strobe: 1 = stop bit sampled high.
REQ-013 framing_error  output  1  one-clock pulse when stop bit sampled low.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 rx_in SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-016 States: IDLE, START, DATA, PARITY, STOP; 3-bit encoding, unused codes return to IDLE.
REQ-017 IDLE: on rx_enable=1 and rx_s falling edge (1 to 0), go START, clear tick counter.
REQ-018 Tick counter increments only on baud_tick, range 0..OVERSAMPLE-1, wraps to 0.
REQ-019 Sample point SP = OVERSAMPLE/2-1 (7 at default); bit decision taken on the baud_tick where counter equals SP.
REQ-020 START at SP: rx_s=0 -> pulse start_check, clear counter, go DATA; rx_s=1 -> glitch, go IDLE, no strobes.
REQ-021 DATA: at each SP capture rx_bit, pulse rx_data_signal, output bit_index; after bit DATA_BITS-1 go PARITY.
REQ-022 PARITY: at SP capture bit, strobe with bit_index=DATA_BITS, go STOP; no parity evaluation in this block.
REQ-023 STOP: at SP capture bit, strobe with bit_index=DATA_BITS+1, set stop_check=rx_s, pulse framing_error if rx_s=0, go IDLE.
REQ-024 After STOP with framing error, IDLE SHALL require rx_s to return high before a new falling edge is accepted.
REQ-025 rx_enable low in any non-IDLE state: return to IDLE next clock, no further strobes, counter cleared.
REQ-026 Strobes (rx_data_signal, start_check, framing_error) SHALL never be high for more than one clock and never simultaneously.
REQ-027 Latency: rx_data_signal asserts one clock after the qualifying baud_tick; rx_bit valid in the same cycle.
REQ-028 baud_tick absent: state and counter hold indefinitely.

Reset
REQ-029 Reset SHALL force state IDLE, counter 0, synchronizer flops 1, rx_bit 1, stop_check 0, bit_index 0, all strobes 0, busy 0.
REQ-030 Reset mid-frame SHALL discard the frame; no strobe in the cycle after reset release.

Configuration
REQ-031 Macro RX_MAJORITY_VOTE_EN defined: each bit value is the 2-of-3 majority of rx_s at counter SP, SP+1, SP+2; decision and strobe at SP+2.
REQ-032 Macro undefined: single sample of rx_s at SP; no vote logic synthesized.

Verification
REQ-033 Frame 0xA5, parity 0, stop 1, OVERSAMPLE 16 -> start_check once, 10 strobes, rx_bit sequence 1,0,1,0,0,1,0,1,0,1, stop_check=1, no framing_error.
REQ-034 rx_in low for 4 baud_ticks in IDLE -> no start_check, state back to IDLE, busy low after SP.
REQ-035 Frame 0x3C with stop bit 0 -> framing_error one pulse with bit_index 9, stop_check=0; next frame not accepted until line high.
REQ-036 rx_enable dropped after data bit 3 -> busy low next clock, no further rx_data_signal.
REQ-037 Reset asserted during DATA bit 5 -> all outputs at reset values; subsequent 0x55 frame received correctly.
REQ-038 RX_MAJORITY_VOTE_EN defined, single-tick glitch on data bit 2 at SP+1 -> rx_bit for bit 2 unchanged; strobe two ticks later than without macro.

Source files
------------

// File: rtl/rx_bit_sampler_if.sv
// Signal bundle between a baud-rate source / line driver and rx_bit_sampler.
// The debug view of the sampler FSM (fsm_state) travels with the bus.
interface rx_bit_sampler_if;
  // Handshake: rx_data_signal and start_check are valid-only strobes with no
  // ready; each is high for exactly one clock and its payload (rx_bit,
  // bit_index, stop_check) is stable in that cycle and held until the next strobe.
  logic       baud_tick;
  logic       rx_enable;
  logic       rx_in;
  logic       rx_bit;
  logic       rx_data_signal;
  logic       start_check;
  logic [3:0] bit_index;
  logic       stop_check;
  logic       framing_error;
  logic       busy;
  logic [2:0] fsm_state;

  modport master (
    output baud_tick, rx_enable, rx_in,
    input  rx_bit, rx_data_signal, start_check, bit_index,
           stop_check, framing_error, busy, fsm_state
  );

  modport slave (
    input  baud_tick, rx_enable, rx_in,
    output rx_bit, rx_data_signal, start_check, bit_index,
           stop_check, framing_error, busy, fsm_state
  );
endinterface

// File: rtl/rx_bit_sampler.sv
// Oversampling UART bit sampler: start/data/parity/stop bit decisions at mid-bit.
// Optional macro RX_MAJORITY_VOTE_EN: 2-of-3 vote over ticks SP..SP+2.
module rx_bit_sampler #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input logic          clock,
  input logic          reset,
  rx_bit_sampler_if.slave bus
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] SP       = CNT_W'(OVERSAMPLE / 2 - 1);
`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [CNT_W-1:0] SP1      = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] DEC_PT   = CNT_W'(OVERSAMPLE / 2 + 1);
`else
  localparam logic [CNT_W-1:0] DEC_PT   = SP;
`endif
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] PAR_IDX   = 4'(DATA_BITS);
  localparam logic [3:0] STOP_IDX  = 4'(DATA_BITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t           state, next_state;
  logic             rx_q1, rx_s, rx_s_d;
  logic             fell;
  logic [CNT_W-1:0] tick_cnt;
  logic [3:0]       bit_cnt;
  logic             decide;
  logic             sample_bit;

  logic             start_d, data_d, stop_d;
  logic [3:0]       idx_d;
  logic             rx_bit_q, data_q, start_q, stop_check_q, fe_q;
  logic [3:0]       idx_q;

  // rx_s_d is the previous synchronized level, used only for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_q1  <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_q1  <= bus.rx_in;
      rx_s   <= rx_q1;
      rx_s_d <= rx_s;
    end
  end

  assign fell = rx_s_d & ~rx_s;

  // The tick counter runs freely across bit boundaries so every later
  // decision lands OVERSAMPLE ticks after the previous one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (state == ST_IDLE || !bus.rx_enable) begin
      tick_cnt <= '0;
    end else if (bus.baud_tick) begin
      tick_cnt <= (tick_cnt == CNT_LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

  assign decide = bus.baud_tick && (tick_cnt == DEC_PT) && bus.rx_enable &&
                  (state != ST_IDLE);

`ifdef RX_MAJORITY_VOTE_EN
  logic vote_a, vote_b;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vote_a <= 1'b1;
      vote_b <= 1'b1;
    end else if (bus.baud_tick) begin
      if (tick_cnt == SP)  vote_a <= rx_s;
      if (tick_cnt == SP1) vote_b <= rx_s;
    end
  end

  assign sample_bit = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
`else
  assign sample_bit = rx_s;
`endif

  // Data bit position; cleared whenever the frame is not in its data phase
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt <= 4'd0;
    end else if (state != ST_DATA) begin
      bit_cnt <= 4'd0;
    end else if (decide) begin
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (bus.rx_enable && fell) next_state = ST_START;
      ST_START:  if (!bus.rx_enable) next_state = ST_IDLE;
                 else if (decide)    next_state = sample_bit ? ST_IDLE : ST_DATA;
      ST_DATA:   if (!bus.rx_enable) next_state = ST_IDLE;
                 else if (decide && bit_cnt == LAST_DATA) next_state = ST_PARITY;
      ST_PARITY: if (!bus.rx_enable) next_state = ST_IDLE;
                 else if (decide)    next_state = ST_STOP;
      ST_STOP:   if (!bus.rx_enable || decide) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    start_d = 1'b0;
    data_d  = 1'b0;
    idx_d   = 4'd0;
    case (state)
      ST_START:  start_d = decide & ~sample_bit;
      ST_DATA:   begin data_d = decide; idx_d = bit_cnt;  end
      ST_PARITY: begin data_d = decide; idx_d = PAR_IDX;  end
      ST_STOP:   begin data_d = decide; idx_d = STOP_IDX; end
      default:   ;
    endcase
    stop_d = data_d && (state == ST_STOP);
  end

  // framing_error trails the stop strobe by one clock so no two strobes coincide
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_bit_q     <= 1'b1;
      data_q       <= 1'b0;
      start_q      <= 1'b0;
      idx_q        <= 4'd0;
      stop_check_q <= 1'b0;
      fe_q         <= 1'b0;
    end else begin
      start_q <= start_d;
      data_q  <= data_d;
      if (data_d) begin
        rx_bit_q <= sample_bit;
        idx_q    <= idx_d;
      end
      if (stop_d) stop_check_q <= sample_bit;
      fe_q <= data_q && (idx_q == STOP_IDX) && !stop_check_q && bus.rx_enable;
    end
  end

  assign bus.rx_bit         = rx_bit_q;
  assign bus.rx_data_signal = data_q;
  assign bus.start_check    = start_q;
  assign bus.bit_index      = idx_q;
  assign bus.stop_check     = stop_check_q;
  assign bus.framing_error  = fe_q;
  assign bus.busy           = (state != ST_IDLE);
  assign bus.fsm_state      = state;

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Bench for rx_bit_sampler: table-driven frames, hand-written corner sequences
// and random frame streams checked against a per-tick line model.
module tb_rx_bit_sampler;
  localparam int OS = 16;
  localparam int DB = 8;
`ifdef RX_MAJORITY_VOTE_EN
  localparam int VOFF = 2;
`else
  localparam int VOFF = 0;
`endif
  localparam int SPT = OS / 2 - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rx_bit_sampler_if bus();

  rx_bit_sampler #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int tick_cnt = 0;
  int n_start = 0;

  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  logic        seg[$];

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [9:0] exp_bits;
    logic       exp_fe;
  } tv_t;

  tv_t tv[6];

  function automatic logic [23:0] mk_ev(int t, logic [1:0] k, logic [3:0] i, logic b, logic s);
    logic [15:0] t16;
    t16 = t[15:0];
    return {t16, k, i, b, s};
  endfunction

  always @(posedge clock) if (bus.baud_tick) tick_cnt <= tick_cnt + 1;

  // Strobe monitor: every strobe becomes one event tagged with the tick count
  always @(negedge clock) begin
    int ns;
    ns = 0;
    if (!reset) begin
      ns = int'(bus.start_check) + int'(bus.rx_data_signal) + int'(bus.framing_error);
      if (ns > 0) begin
        n_cmp++;
        if (ns > 1) begin
          n_err++;
          $display("FAIL strobe_overlap: %0d strobes high, required at most 1", ns);
        end
      end
      if (bus.start_check) begin
        n_start++;
        obs_q.push_back(mk_ev(tick_cnt, 2'd1, 4'd0, 1'b0, 1'b0));
      end
      if (bus.rx_data_signal)
        obs_q.push_back(mk_ev(tick_cnt, 2'd2, bus.bit_index, bus.rx_bit,
                              (bus.bit_index == 4'(DB + 1)) ? bus.stop_check : 1'b0));
      if (bus.framing_error)
        obs_q.push_back(mk_ev(tick_cnt, 2'd3, bus.bit_index, 1'b0, bus.stop_check));
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line value v is applied three clocks before the tick that samples it
  task automatic tick_with(input logic v);
    @(negedge clock);
    bus.baud_tick = 1'b0;
    bus.rx_in     = v;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    bus.baud_tick = 1'b1;
  endtask

  task automatic settle();
    @(negedge clock);
    bus.baud_tick = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic add_level(input logic v, input int n);
    for (int i = 0; i < n; i++) seg.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] d, input logic p, input logic s);
    add_level(1'b0, OS);
    for (int i = 0; i < DB; i++) add_level(d[i], OS);
    add_level(p, OS);
    add_level(s, OS);
  endtask

  function automatic logic seg_at(int i);
    return (i >= 0 && i < seg.size()) ? seg[i] : 1'b1;
  endfunction

  function automatic logic samp(int c);
    logic a, b, e;
    a = seg_at(c);
    b = seg_at(c + 1);
    e = seg_at(c + 2);
    return (VOFF == 0) ? a : ((a & b) | (a & e) | (b & e));
  endfunction

  // Reference: a start is a 1->0 change of the per-tick line; each bit is
  // taken at ticks start+SPT+OS*n, the strobe lands VOFF ticks later.
  task automatic model_seg(input int base);
    int t, k, c, d;
    logic prev, v;
    prev = 1'b1;
    t = 0;
    while (t < seg.size()) begin
      if (prev && !seg[t]) begin
        k = t;
        d = k + SPT + VOFF;
        if (samp(k + SPT)) begin
          prev = seg_at(d);
          t = d + 1;
        end else begin
          exp_q.push_back(mk_ev(base + 1 + d, 2'd1, 4'd0, 1'b0, 1'b0));
          for (int j = 0; j < DB + 2; j++) begin
            c = k + SPT + OS * (j + 1);
            d = c + VOFF;
            v = samp(c);
            exp_q.push_back(mk_ev(base + 1 + d, 2'd2, 4'(j), v, (j == DB + 1) ? v : 1'b0));
            if (j == DB + 1 && !v)
              exp_q.push_back(mk_ev(base + 1 + d, 2'd3, 4'(DB + 1), 1'b0, 1'b0));
          end
          prev = seg_at(d);
          t = d + 1;
        end
      end else begin
        prev = seg[t];
        t++;
      end
    end
  endtask

  task automatic drop_exp_after(input int last_tick);
    logic [23:0] keep_q[$];
    foreach (exp_q[i]) if (int'(exp_q[i][23:8]) <= last_tick) keep_q.push_back(exp_q[i]);
    exp_q = keep_q;
  endtask

  task automatic sb_compare(input string name);
    check({name, "_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) check(name, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic drive_seg();
    foreach (seg[i]) tick_with(seg[i]);
    settle();
  endtask

  task automatic run_seg(input string name);
    model_seg(tick_cnt);
    drive_seg();
    sb_compare(name);
    seg.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_bit"}, bus.rx_bit, 1'b1);
    check({tag, "_rx_data_signal"}, bus.rx_data_signal, 1'b0);
    check({tag, "_start_check"}, bus.start_check, 1'b0);
    check({tag, "_bit_index"}, bus.bit_index, 4'd0);
    check({tag, "_stop_check"}, bus.stop_check, 1'b0);
    check({tag, "_framing_error"}, bus.framing_error, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_state"}, bus.fsm_state, 3'd0);
  endtask

  initial begin
    int base, cut, st0;
    tv[0] = '{8'hA5, 1'b0, 1'b1, 10'h2A5, 1'b0};
    tv[1] = '{8'h3C, 1'b0, 1'b0, 10'h03C, 1'b1};
    tv[2] = '{8'h55, 1'b1, 1'b1, 10'h355, 1'b0};
    tv[3] = '{8'hFF, 1'b1, 1'b1, 10'h3FF, 1'b0};
    tv[4] = '{8'h00, 1'b0, 1'b1, 10'h200, 1'b0};
    tv[5] = '{8'h81, 1'b0, 1'b0, 10'h081, 1'b1};

    reset = 1'b1;
    bus.baud_tick = 1'b0;
    bus.rx_enable = 1'b1;
    bus.rx_in     = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // Table frames: expected strobes come straight from the table bits
    for (int n = 0; n < 6; n++) begin
      add_level(1'b1, 2);
      add_frame(tv[n].data, tv[n].par, tv[n].stop);
      add_level(1'b1, 4);
      base = tick_cnt;
      exp_q.push_back(mk_ev(base + 1 + 2 + SPT + VOFF, 2'd1, 4'd0, 1'b0, 1'b0));
      for (int j = 0; j < DB + 2; j++)
        exp_q.push_back(mk_ev(base + 1 + 2 + SPT + OS * (j + 1) + VOFF, 2'd2, 4'(j),
                              tv[n].exp_bits[j], (j == DB + 1) ? tv[n].exp_bits[j] : 1'b0));
      if (tv[n].exp_fe)
        exp_q.push_back(mk_ev(base + 1 + 2 + SPT + OS * (DB + 2) + VOFF, 2'd3, 4'(DB + 1), 1'b0, 1'b0));
      drive_seg();
      sb_compare("table_frame");
      seg.delete();
    end

    // Short low pulse in IDLE: rejected at the start sample point
    add_level(1'b1, 2);
    add_level(1'b0, 4);
    add_level(1'b1, 12);
    model_seg(tick_cnt);
    for (int i = 0; i < seg.size(); i++) begin
      tick_with(seg[i]);
      if (i == 4) check("glitch_busy_during", bus.busy, 1'b1);
    end
    settle();
    check("glitch_busy_after", bus.busy, 1'b0);
    sb_compare("glitch_start");
    seg.delete();

    // Framing error, line held low, then a clean frame once the line recovers
    st0 = n_start;
    add_level(1'b1, 2);
    add_frame(8'h3C, 1'b0, 1'b0);
    add_level(1'b0, 20);
    add_level(1'b1, 3);
    add_frame(8'h55, 1'b1, 1'b1);
    add_level(1'b1, 4);
    run_seg("fe_recover");
    check("fe_recover_starts", n_start - st0, 2);

    // rx_enable dropped right after the data bit 3 strobe
    add_level(1'b1, 2);
    add_frame(8'hC3, 1'b1, 1'b1);
    add_level(1'b1, 4);
    base = tick_cnt;
    model_seg(base);
    cut = 2 + SPT + OS * 4 + VOFF;
    drop_exp_after(base + 1 + cut);
    for (int i = 0; i <= cut; i++) tick_with(seg[i]);
    @(negedge clock);
    bus.baud_tick = 1'b0;
    check("en_drop_busy_before", bus.busy, 1'b1);
    bus.rx_enable = 1'b0;
    @(negedge clock);
    check("en_drop_busy_after", bus.busy, 1'b0);
    for (int i = cut + 1; i < seg.size(); i++) tick_with(seg[i]);
    settle();
    bus.rx_enable = 1'b1;
    sb_compare("en_drop");
    seg.delete();

    // Reset during data bit 5, then a 0x55 frame
    add_level(1'b1, 2);
    add_frame(8'hA5, 1'b0, 1'b1);
    base = tick_cnt;
    model_seg(base);
    cut = 2 + OS * 6 + 4;
    drop_exp_after(base + 1 + cut);
    for (int i = 0; i <= cut; i++) tick_with(seg[i]);
    @(negedge clock);
    bus.baud_tick = 1'b0;
    bus.rx_in = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_values("mid_reset");
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    sb_compare("pre_reset");
    seg.delete();
    add_level(1'b1, 3);
    add_frame(8'h55, 1'b0, 1'b1);
    add_level(1'b1, 4);
    run_seg("post_reset");

    // Single-tick glitches on data bit 2 (at SP+1) and data bit 4 (at SP)
    add_level(1'b1, 2);
    add_frame(8'hA5, 1'b0, 1'b1);
    add_level(1'b1, 4);
    seg[2 + SPT + OS * 3 + 1] = ~seg[2 + SPT + OS * 3 + 1];
    seg[2 + SPT + OS * 5]     = ~seg[2 + SPT + OS * 5];
    run_seg("bit_glitch");

    // Random frame stream with occasional rejected start pulses
    for (int r = 0; r < 20; r++) begin
      add_level(1'b1, $urandom_range(1, 5));
      if ($urandom_range(0, 4) == 0) begin
        add_level(1'b0, $urandom_range(1, 6));
        add_level(1'b1, $urandom_range(10, 14));
      end
      add_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 5) != 0));
    end
    add_level(1'b1, 4);
    run_seg("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
